// File: rtl/gb_cart_pkg.sv
// Shared definitions for the Game Boy cartridge bus host: FSM states,
// cartridge address map and MBC1 control-register bases.
package gb_cart_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4
  } gb_state_e;

  localparam logic [15:0] ROM_LO  = 16'h0000;
  localparam logic [15:0] ROM_HI  = 16'h7FFF;
  localparam logic [15:0] ERAM_LO = 16'hA000;
  localparam logic [15:0] ERAM_HI = 16'hBFFF;

  localparam logic [15:0] MBC1_RAM_EN   = 16'h0000;
  localparam logic [15:0] MBC1_ROM_BANK = 16'h2000;
  localparam logic [15:0] MBC1_RAM_BANK = 16'h4000;
  localparam logic [15:0] MBC1_MODE     = 16'h6000;

  // True when the address selects cartridge external RAM (drives cs_n).
  function automatic logic is_eram(input logic [15:0] addr);
    return (addr >= ERAM_LO) && (addr <= ERAM_HI);
  endfunction

endpackage

// File: rtl/gb_phase_timer.sv
// 4-bit loadable down-counter timing one bus phase; saturates at zero.
module gb_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_done
);

  logic [3:0] r_cnt;

  // Load on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/gb_cart_host.sv
// Command-driven Game Boy cartridge bus master: holds the cartridge in reset
// for T_RST cycles, then runs one setup/strobe/hold access per command.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RST_HOLD | cartridge reset asserted, T_RST cycles, no commands
// IDLE     | ready for a command; address pins keep the last access
// SETUP    | address (and write data) driven, strobes high
// STROBE   | gb_read_n or gb_write_n low; read data sampled on last cycle
// HOLD     | strobes high, address/data still driven
module gb_cart_host
  import gb_cart_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1,
  parameter int T_RST    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] gb_addr,
  output logic [7:0]  gb_data_out,
  output logic        gb_data_oe,
  input  logic [7:0]  gb_data_in,
  output logic        gb_read_n,
  output logic        gb_write_n,
  output logic        cs_n,
  output logic        gb_rst_n
);

  localparam logic [3:0] L_SETUP  = 4'(T_SETUP - 1);
  localparam logic [3:0] L_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] L_HOLD   = 4'(T_HOLD - 1);
  localparam logic [7:0] L_RST    = 8'(T_RST - 1);

  gb_state_e   r_state, w_state_n;
  logic [7:0]  r_rst_cnt;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_write;
  logic [7:0]  r_rdata;
  logic        r_rsp_valid;
  logic        w_load;
  logic [3:0]  w_load_val;
  logic        w_done;
  logic        w_accept;
  logic        w_busy;

  gb_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_busy   = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_HOLD;
    else        r_state <= w_state_n;
  end

  // Next-state decode; the phase timer is reloaded on every phase entry.
  always_comb begin
    w_state_n  = r_state;
    w_load     = 1'b0;
    w_load_val = 4'd0;
    case (r_state)
      RST_HOLD: if (r_rst_cnt == 8'd0) w_state_n = IDLE;
      IDLE: if (cmd_valid) begin
        w_state_n  = SETUP;
        w_load     = 1'b1;
        w_load_val = L_SETUP;
      end
      SETUP: if (w_done) begin
        w_state_n  = STROBE;
        w_load     = 1'b1;
        w_load_val = L_STROBE;
      end
      STROBE: if (w_done) begin
        w_state_n  = HOLD;
        w_load     = 1'b1;
        w_load_val = L_HOLD;
      end
      HOLD: if (w_done) w_state_n = IDLE;
      default: w_state_n = RST_HOLD;
    endcase
  end

  // Cartridge reset length counter; T_RST can exceed the 4-bit phase timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt <= L_RST;
    end else if ((r_state == RST_HOLD) && (r_rst_cnt != 8'd0)) begin
      r_rst_cnt <= r_rst_cnt - 8'd1;
    end
  end

  // Command latch, read-data capture and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_write     <= 1'b0;
      r_rdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (r_state == HOLD) && w_done;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_write <= cmd_write;
        if (cmd_write) r_rdata <= 8'h00;
      end
      if ((r_state == STROBE) && w_done && !r_write) begin
        r_rdata <= gb_data_in;
      end
    end
  end

  // Pin outputs decode straight from state so async reset reaches them at once.
  assign cmd_ready   = (r_state == IDLE);
  assign gb_rst_n    = (r_state != RST_HOLD);
  assign gb_addr     = r_addr;
  assign gb_read_n   = !((r_state == STROBE) && !r_write);
  assign gb_write_n  = !((r_state == STROBE) && r_write);
  assign gb_data_oe  = w_busy && r_write;
  assign gb_data_out = gb_data_oe ? r_wdata : 8'h00;
  assign cs_n        = !(w_busy && is_eram(r_addr));
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_gb_cart_host.sv
// Directed bench for gb_cart_host with default timing parameters
// (setup 2, strobe 4, hold 1, cartridge reset 16).
module tb_gb_cart_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] gb_addr;
  logic [7:0]  gb_data_out;
  logic        gb_data_oe;
  logic [7:0]  gb_data_in = 8'h00;
  logic        gb_read_n, gb_write_n, cs_n, gb_rst_n;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  gb_cart_host dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .gb_addr     (gb_addr),
    .gb_data_out (gb_data_out),
    .gb_data_oe  (gb_data_oe),
    .gb_data_in  (gb_data_in),
    .gb_read_n   (gb_read_n),
    .gb_write_n  (gb_write_n),
    .cs_n        (cs_n),
    .gb_rst_n    (gb_rst_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts posedges after reset release until gb_rst_n rises (bounded).
  task automatic count_rst(input string tag);
    int n = 0;
    int ready_bad = 0;
    int rsp_seen = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (cmd_ready && !gb_rst_n) ready_bad++;
      if (rsp_valid) rsp_seen++;
    end while (!gb_rst_n && n < 100);
    check({tag, "_len"}, n, 16);
    check({tag, "_ready_low"}, ready_bad, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
    check({tag, "_no_rsp"}, rsp_seen, 0);
  endtask

  // One access, observed for the 8 cycles after acceptance. Called #1 after a
  // posedge with the DUT in IDLE; returns #1 after the posedge that starts
  // cycle 8 (the rsp_valid cycle). With hold=1 cmd_valid stays high.
  task automatic do_access(input string tag, input logic w, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] din, input logic hold);
    int rd_lo = 0, wr_lo = 0, oe_hi = 0, cs_lo = 0, ovl = 0;
    int addr_bad = 0, dout_bad = 0, rsp_at = 0;
    logic [7:0] rd_got = 8'h00;
    logic exp_cs;
    exp_cs = (a >= 16'hA000) && (a <= 16'hBFFF);
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wdata  = wd;
    gb_data_in = ~din;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (!gb_read_n) rd_lo++;
      if (!gb_write_n) wr_lo++;
      if (gb_data_oe) oe_hi++;
      if (!cs_n) cs_lo++;
      if (!gb_read_n && !gb_write_n) ovl++;
      if (gb_addr !== a) addr_bad++;
      if (gb_data_oe && gb_data_out !== wd) dout_bad++;
      if (rsp_valid && rsp_at == 0) begin
        rsp_at = k;
        rd_got = rsp_rdata;
      end
      if (k == 1) begin
        check({tag, "_busy"}, cmd_ready, 0);
        check({tag, "_rsp_early"}, rsp_valid, 0);
        check({tag, "_setup_strb"}, {gb_read_n, gb_write_n}, 2'b11);
        if (!hold) cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
      end
      if (k == 6) gb_data_in = din;
      if (k == 7) gb_data_in = ~din;
    end
    check({tag, "_rd_low"}, rd_lo, w ? 0 : 4);
    check({tag, "_wr_low"}, wr_lo, w ? 4 : 0);
    check({tag, "_oe_high"}, oe_hi, w ? 7 : 0);
    check({tag, "_cs_low"}, cs_lo, exp_cs ? 7 : 0);
    check({tag, "_overlap"}, ovl, 0);
    check({tag, "_addr"}, addr_bad, 0);
    check({tag, "_dout"}, dout_bad, 0);
    check({tag, "_rsp_cycle"}, rsp_at, 8);
    check({tag, "_rdata"}, rd_got, w ? 8'h00 : din);
    check({tag, "_ready_rsp"}, cmd_ready, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gb_rst_n", gb_rst_n, 0);
    check("rst_strobes", {gb_read_n, gb_write_n, cs_n}, 3'b111);
    check("rst_oe", gb_data_oe, 0);
    check("rst_dout", gb_data_out, 8'h00);
    check("rst_addr", gb_addr, 16'h0000);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    count_rst("rel");

    do_access("wr2000", 1'b1, 16'h2000, 8'h05, 8'h00, 1'b0);
    do_access("rd4123", 1'b0, 16'h4123, 8'h00, 8'h3C, 1'b0);
    do_access("wr0000", 1'b1, 16'h0000, 8'h0A, 8'h00, 1'b0);
    do_access("rdA010", 1'b0, 16'hA010, 8'h00, 8'h5A, 1'b0);
    check("idle_addr", gb_addr, 16'hA010);

    do_access("b2b_1", 1'b1, 16'hA000, 8'h11, 8'h00, 1'b1);
    do_access("b2b_2", 1'b0, 16'h1234, 8'h00, 8'h22, 1'b1);
    do_access("b2b_3", 1'b0, 16'hBFFF, 8'h00, 8'h33, 1'b1);
    cmd_valid = 1'b0;

    do_access("rdC000", 1'b0, 16'hC000, 8'h00, 8'h99, 1'b0);
    do_access("rd9FFF", 1'b0, 16'h9FFF, 8'h00, 8'h01, 1'b0);

    // Reset during the strobe of an external-RAM write.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'hA123;
    cmd_wdata = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_strobe", {gb_write_n, gb_data_oe, cs_n}, 3'b010);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {gb_read_n, gb_write_n, cs_n}, 3'b111);
    check("abort_oe", {gb_data_oe, gb_data_out}, 9'h000);
    check("abort_gb_rst", gb_rst_n, 0);
    check("abort_rsp", rsp_valid, 0);
    check("abort_addr", gb_addr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    count_rst("rerun");
    do_access("post_rst", 1'b0, 16'h0150, 8'h00, 8'hC3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
